// File: rtl/bist_checker.sv
// rtl/bist_checker.sv - BIST read-response checker with sticky fail/done status.
// Define BIST_CHECKER_DIAG_EN to add the mismatch counter and first-failure address/syndrome.
module bist_checker #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] check,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  patgen_done,
    output logic                  fail,
    output logic                  done
`ifdef BIST_CHECKER_DIAG_EN
    ,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_syndrome
`endif
);

    localparam int LAST = READ_LATENCY - 1;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_check [READ_LATENCY];
    logic                    done_seen;
    logic                    issue;
    logic                    mismatch;
    logic                    drained;
    logic [DATA_WIDTH-1:0]   syndrome;

    assign issue    = en && re && !done_seen;
    assign syndrome = dout ^ pipe_check[LAST];
    assign mismatch = pipe_valid[LAST] && (syndrome != '0);
    assign drained  = (pipe_valid == '0);

    // Delay line matched to SRAM read latency; shifts every cycle, no stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_check[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_check[0] <= check;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_check[i] <= pipe_check[i-1];
            end
        end
    end

    // done waits for the final in-flight compare to register before asserting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_seen <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            if (patgen_done) begin
                done_seen <= 1'b1;
            end
            if (done_seen && drained) begin
                done <= 1'b1;
            end
            if (mismatch) begin
                fail <= 1'b1;
            end
        end
    end

`ifdef BIST_CHECKER_DIAG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_addr[0] <= addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    // Address and syndrome freeze on the first mismatch; the counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt      <= '0;
            fail_addr     <= '0;
            fail_syndrome <= '0;
        end else if (mismatch) begin
            if (fail_cnt != '1) begin
                fail_cnt <= fail_cnt + CNT_WIDTH'(1);
            end
            if (!fail) begin
                fail_addr     <= pipe_addr[LAST];
                fail_syndrome <= syndrome;
            end
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^addr;
`endif

endmodule
